instr_loader: RTL and testbench

- Boot-time loader upstream of the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words into the instruction memory write port, verifies a trailing XOR checksum, then releases the core's synchronous reset.
- Sits between the byte-transport front end (UART or debug bridge) and the instruction memory / core reset.

---
 rtl/instr_loader_pkg.sv | 17 +
 rtl/byte_to_word_packer.sv | 37 +++
 rtl/instr_loader.sv | 113 +++++++++++
 tb/tb_instr_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    CHECK,
    RUN,
    ERROR
  } loadState_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles little-endian words from a byte stream; pulses wordDone on the byte that completes a word.
module byte_to_word_packer
  import instr_loader_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_arstn,
  input  logic                        i_clear,
  input  logic                        i_shiftEn,
  input  logic [7:0]                  i_byte,
  output logic [8*BYTES_PER_WORD-1:0] o_word,
  output logic                        o_wordDone
);

  logic [BYTE_IDX_W-1:0]          byteIdx;
  logic [BYTES_PER_WORD-1:0][7:0] wordBuf;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      byteIdx <= '0;
      wordBuf <= '0;
    end else if (i_clear) begin
      byteIdx <= '0;
      wordBuf <= '0;
    end else if (i_shiftEn) begin
      wordBuf[byteIdx] <= i_byte;
      byteIdx          <= byteIdx + 1'b1;
    end
  end

  // The word is presented in the same cycle as its final byte so the caller can register it directly.
  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : gLane
    assign o_word[8*g +: 8] = (i_shiftEn && byteIdx == BYTE_IDX_W'(g)) ? i_byte : wordBuf[g];
  end

  assign o_wordDone = i_shiftEn && (byteIdx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, XOR-checked, then core release.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_arstn,
  input  logic        i_restart,
  input  logic        i_byteValid,
  input  logic [7:0]  i_byteData,
  output logic        o_byteReady,
  output logic        o_imemWriteEn,
  output logic [31:0] o_imemAddress,
  output logic [31:0] o_imemWriteData,
  output logic        o_coreSrst,
  output logic        o_loadDone,
  output logic        o_loadError
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  loadState_e        state, nextState;
  logic              byteReady;
  logic              accept, restartGo, lastWord;
  logic              pkShift, pkDone;
  logic [31:0]       pkWord;
  logic [31:0]       lenWord;
  logic [IDX_W-1:0]  wordIndex;
  logic [CSUM_W-1:0] checksum;
  logic              writeEn;
  logic [31:0]       writeData, address;

  assign accept    = i_byteValid && byteReady;
  assign restartGo = i_restart && (state == RUN || state == ERROR);
  assign pkShift   = accept && (state == LEN || state == DATA);
  assign lastWord  = (32'(wordIndex) + 32'd1) == lenWord;

  // Same packer serves the length field and every data word; it wraps to index 0 between fields.
  byte_to_word_packer u_packer (
    .i_clk      (i_clk),
    .i_arstn    (i_arstn),
    .i_clear    (restartGo),
    .i_shiftEn  (pkShift),
    .i_byte     (i_byteData),
    .o_word     (pkWord),
    .o_wordDone (pkDone)
  );

  always_comb begin
    nextState = state;
    case (state)
      LEN: begin
        if (accept && pkDone) begin
          if (pkWord > 32'(DEPTH_WORDS)) nextState = ERROR;
          else if (pkWord == 32'd0)      nextState = CHECK;
          else                           nextState = DATA;
        end
      end
      DATA:       if (accept && pkDone && lastWord) nextState = CHECK;
      CHECK:      if (accept) nextState = (i_byteData == checksum) ? RUN : ERROR;
      RUN, ERROR: if (i_restart) nextState = LEN;
      default:    nextState = LEN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state     <= LEN;
      byteReady <= 1'b0;
    end else begin
      state     <= nextState;
      byteReady <= (nextState == LEN) || (nextState == DATA) || (nextState == CHECK);
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      lenWord   <= '0;
      wordIndex <= '0;
      checksum  <= '0;
      writeEn   <= 1'b0;
      writeData <= '0;
      address   <= BASE_ADDR;
    end else begin
      writeEn <= 1'b0;
      if (restartGo) begin
        lenWord   <= '0;
        wordIndex <= '0;
        checksum  <= '0;
      end else if (accept) begin
        checksum <= checksum ^ i_byteData;
        if (state == LEN && pkDone) lenWord <= pkWord;
        if (state == DATA && pkDone) begin
          writeEn   <= 1'b1;
          writeData <= pkWord;
          address   <= BASE_ADDR + (32'(wordIndex) << 2);
          wordIndex <= wordIndex + 1'b1;
        end
      end
    end
  end

  assign o_byteReady     = byteReady;
  assign o_imemWriteEn   = writeEn;
  assign o_imemAddress   = address;
  assign o_imemWriteData = writeData;
  assign o_coreSrst      = (state != RUN);
  assign o_loadDone      = (state == RUN);
  assign o_loadError     = (state == ERROR);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stream-level reference model plus hand-computed literal checks.
module tb_instr_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_arstn = 1'b1;
  logic        i_restart = 1'b0;
  logic        i_byteValid = 1'b0;
  logic [7:0]  i_byteData = 8'h00;
  logic        o_byteReady, o_imemWriteEn, o_coreSrst, o_loadDone, o_loadError;
  logic [31:0] o_imemAddress, o_imemWriteData;

  instr_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk           (i_clk),
    .i_arstn         (i_arstn),
    .i_restart       (i_restart),
    .i_byteValid     (i_byteValid),
    .i_byteData      (i_byteData),
    .o_byteReady     (o_byteReady),
    .o_imemWriteEn   (o_imemWriteEn),
    .o_imemAddress   (o_imemAddress),
    .o_imemWriteData (o_imemWriteData),
    .o_coreSrst      (o_coreSrst),
    .o_loadDone      (o_loadDone),
    .o_loadError     (o_loadError)
  );

  always #5 i_clk = ~i_clk;

  int nVec = 0;
  int nFail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: the stream as a list of accepted bytes ----------------
  logic [7:0]  mBytes [0:511];
  int          mCnt = 0;
  bit          mLive = 0;
  bit          mWr = 0;
  logic [31:0] mAddr = BASE;
  logic [31:0] mData = 32'h0;

  function automatic longint mN();
    return longint'({mBytes[3], mBytes[2], mBytes[1], mBytes[0]});
  endfunction

  function automatic bit mCsumBad();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < mCnt - 1; i++) x ^= mBytes[i];
    return x != mBytes[mCnt-1];
  endfunction

  function automatic bit mErr();
    if (mCnt < 4) return 1'b0;
    if (mN() > DEPTH) return 1'b1;
    return (mCnt == 4 * mN() + 5) && mCsumBad();
  endfunction

  function automatic bit mDone();
    if (mCnt < 4 || mN() > DEPTH) return 1'b0;
    return (mCnt == 4 * mN() + 5) && !mCsumBad();
  endfunction

  function automatic bit mReady();
    return mLive && !mErr() && !mDone();
  endfunction

  always @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      mLive <= 1'b0;
      mCnt  <= 0;
      mWr   <= 1'b0;
      mAddr <= BASE;
      mData <= 32'h0;
    end else begin
      mLive <= 1'b1;
      mWr   <= 1'b0;
      if (mDone() || mErr()) begin
        if (i_restart) mCnt <= 0;
      end else if (mLive && i_byteValid) begin
        mBytes[mCnt] <= i_byteData;
        mCnt         <= mCnt + 1;
        // byte number mCnt+1 closes a data word when it lands on a 4-byte boundary past the header
        if (mCnt >= 4 && (mCnt + 1) % 4 == 0 && longint'(mCnt + 1) <= 4 + 4 * mN()) begin
          mWr   <= 1'b1;
          mData <= {i_byteData, mBytes[mCnt-1], mBytes[mCnt-2], mBytes[mCnt-3]};
          mAddr <= BASE + 32'(mCnt + 1 - 8);
        end
      end
    end
  end

  // ---------------- per-cycle compare + write monitor ----------------
  int          wrCyc[$];
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge i_clk);
      chk("byteReady", 32'(o_byteReady), 32'(mReady()));
      chk("writeEn",   32'(o_imemWriteEn), 32'(mWr));
      chk("address",   o_imemAddress, mAddr);
      chk("writeData", o_imemWriteData, mData);
      chk("coreSrst",  32'(o_coreSrst), 32'(!mDone()));
      chk("loadDone",  32'(o_loadDone), 32'(mDone()));
      chk("loadError", 32'(o_loadError), 32'(mErr()));
      if (o_imemWriteEn) begin
        wrCyc.push_back(cyc);
        wrAddr.push_back(o_imemAddress);
        wrData.push_back(o_imemWriteData);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] stream[$];

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic buildStream(input int n, input logic [31:0] seed, input bit badCsum);
    logic [7:0]  x;
    logic [31:0] w, len;
    stream.delete();
    len = 32'(n);
    for (int b = 0; b < 4; b++) stream.push_back(len[8*b +: 8]);
    for (int i = 0; i < n; i++) begin
      w = seed + 32'(i) * 32'h0101_0101;
      for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
    end
    x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(badCsum ? ~x : x);
  endtask

  // Offers stream[first..last]; returns at +2 after the edge that took the last byte.
  task automatic sendBytes(input int first, input int last, input bit gaps);
    int tries;
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          i_byteValid = 1'b0;
          tick();
        end
      end
      i_byteValid = 1'b1;
      i_byteData  = stream[i];
      tries = 0;
      while (!o_byteReady && tries < 20) begin
        tick();
        tries++;
      end
      if (tries >= 20) begin
        nVec++;
        nFail++;
        $display("FAIL acceptTimeout: byte %0d not taken, ready=%0d required 1", i, o_byteReady);
        i_byteValid = 1'b0;
        return;
      end
      tick();
    end
    i_byteValid = 1'b0;
  endtask

  task automatic pulseRestart();
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
  endtask

  initial begin
    int relCyc;
    #1 i_arstn = 1'b0;
    #2;
    chk("rstReady", 32'(o_byteReady), 32'd0);
    chk("rstSrst",  32'(o_coreSrst), 32'd1);
    chk("rstAddr",  o_imemAddress, 32'h0);
    chk("rstData",  o_imemWriteData, 32'h0);
    tick();
    tick();
    i_arstn = 1'b1;
    tick();

    // single word, hand-computed checksum
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    wrCyc.delete(); wrAddr.delete(); wrData.delete();
    sendBytes(0, 8, 1'b0);
    chk("t1Done",    32'(o_loadDone), 32'd1);
    chk("t1Srst",    32'(o_coreSrst), 32'd0);
    chk("t1Writes",  32'(wrCyc.size()), 32'd1);
    chk("t1Addr",    wrAddr[0], 32'h0);
    chk("t1Data",    wrData[0], 32'h0050_0093);
    pulseRestart();
    chk("t1RstSrst", 32'(o_coreSrst), 32'd1);

    // three words, valid held high: strobes 4 cycles apart, release one cycle after last strobe
    buildStream(3, 32'h1122_3344, 1'b0);
    wrCyc.delete(); wrAddr.delete(); wrData.delete();
    sendBytes(0, stream.size() - 1, 1'b0);
    relCyc = cyc;
    chk("t2Done",    32'(o_loadDone), 32'd1);
    chk("t2Writes",  32'(wrCyc.size()), 32'd3);
    if (wrCyc.size() == 3) begin
      chk("t2Gap0",  32'(wrCyc[1] - wrCyc[0]), 32'd4);
      chk("t2Gap1",  32'(wrCyc[2] - wrCyc[1]), 32'd4);
      chk("t2Addr0", wrAddr[0], 32'h0);
      chk("t2Addr1", wrAddr[1], 32'h4);
      chk("t2Addr2", wrAddr[2], 32'h8);
      chk("t2Data2", wrData[2], 32'h1324_3546);
      chk("t2Rel",   32'(relCyc - wrCyc[2]), 32'd1);
    end
    pulseRestart();

    // bad checksum -> error, restart, good reload
    buildStream(2, 32'hDEAD_BEEF, 1'b1);
    sendBytes(0, stream.size() - 1, 1'b0);
    tick();
    chk("t3Err",     32'(o_loadError), 32'd1);
    chk("t3Srst",    32'(o_coreSrst), 32'd1);
    chk("t3Ready",   32'(o_byteReady), 32'd0);
    pulseRestart();
    chk("t3ErrClr",  32'(o_loadError), 32'd0);
    buildStream(2, 32'hDEAD_BEEF, 1'b0);
    sendBytes(0, stream.size() - 1, 1'b1);
    chk("t3Reload",  32'(o_loadDone), 32'd1);
    pulseRestart();

    // oversize length
    stream = '{8'h41, 8'h00, 8'h00, 8'h00};
    wrCyc.delete(); wrAddr.delete(); wrData.delete();
    sendBytes(0, 3, 1'b0);
    chk("t4Err",     32'(o_loadError), 32'd1);
    i_byteValid = 1'b1;
    repeat (3) tick();
    i_byteValid = 1'b0;
    chk("t4Writes",  32'(wrCyc.size()), 32'd0);
    pulseRestart();

    // empty program
    stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sendBytes(0, 4, 1'b0);
    chk("t5Done",    32'(o_loadDone), 32'd1);
    chk("t5Writes",  32'(wrCyc.size()), 32'd0);
    pulseRestart();
    chk("t5Srst",    32'(o_coreSrst), 32'd1);
    chk("t5DoneClr", 32'(o_loadDone), 32'd0);

    // async reset mid word 1, then a full reload with gaps
    buildStream(2, 32'hA5A5_0F0F, 1'b0);
    sendBytes(0, 9, 1'b1);
    i_byteValid = 1'b1;
    i_byteData  = stream[10];
    #1 i_arstn = 1'b0;
    #1;
    chk("t6Ready",   32'(o_byteReady), 32'd0);
    chk("t6Wen",     32'(o_imemWriteEn), 32'd0);
    chk("t6Srst",    32'(o_coreSrst), 32'd1);
    chk("t6Addr",    o_imemAddress, 32'h0);
    tick();
    i_byteValid = 1'b0;
    tick();
    i_arstn = 1'b1;
    tick();
    wrCyc.delete(); wrAddr.delete(); wrData.delete();
    sendBytes(0, stream.size() - 1, 1'b1);
    chk("t6Done",    32'(o_loadDone), 32'd1);
    chk("t6Writes",  32'(wrCyc.size()), 32'd2);
    if (wrData.size() == 2) chk("t6Data1", wrData[1], 32'hA6A6_1010);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
    $fatal(1, "watchdog");
  end

endmodule
